// File: rtl/sram22_arb2_if.sv
// Client request/response bundle for the sram22 two-port arbiter.
// One instance per client; the controller uses the slave side.
interface sram22_arb2_if #(
  parameter int AW = 11,
  parameter int DW = 8,
  parameter int MW = 8
);
  logic          valid;
  logic          ready;
  logic          we;
  logic [MW-1:0] wmask;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          rvalid;
  logic [DW-1:0] rdata;

  modport master (
    output valid, we, wmask, addr, wdata,
    input  ready, rvalid, rdata
  );

  modport slave (
    input  valid, we, wmask, addr, wdata,
    output ready, rvalid, rdata
  );
endinterface

// File: rtl/sram22_arb2_ctrl.sv
// Round-robin two-client controller for one single-port sram22 macro.
// Registered macro command, 2-deep read tag pipe, optional zero sweep.
module sram22_arb2_ctrl #(
  parameter int ADDR_WIDTH  = 11,
  parameter int DATA_WIDTH  = 8,
  parameter int WMASK_WIDTH = 8,
  parameter bit INIT_EN     = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  sram22_arb2_if.slave           a,
  sram22_arb2_if.slave           b,
  output logic                   init_done,
  output logic                   sram_rstb,
  output logic                   sram_ce,
  output logic                   sram_we,
  output logic [WMASK_WIDTH-1:0] sram_wmask,
  output logic [ADDR_WIDTH-1:0]  sram_addr,
  output logic [DATA_WIDTH-1:0]  sram_din,
  input  logic [DATA_WIDTH-1:0]  sram_dout
);

  localparam logic [0:0] S_INIT = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;
  localparam logic [ADDR_WIDTH-1:0] LAST = '1;

  logic [0:0]            r_state;
  logic [ADDR_WIDTH-1:0] r_cnt;
  logic                  r_done;
  logic                  r_last_b;
  logic                  r_ce;
  logic                  r_we;
  logic [WMASK_WIDTH-1:0] r_wmask;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_din;
  logic                  r_t1_v;
  logic                  r_t1_b;
  logic                  r_t2_v;
  logic                  r_t2_b;

  logic w_run;
  logic w_init;
  logic w_a_rdy;
  logic w_b_rdy;

  // Arbitration: lone requester wins, contention goes to the port not served last.
  always_comb begin
    w_run   = (r_state == S_RUN) && !rst;
    w_init  = (r_state == S_INIT);
    w_a_rdy = w_run && a.valid && (!b.valid || r_last_b);
    w_b_rdy = w_run && b.valid && (!a.valid || !r_last_b);
  end

  assign a.ready    = w_a_rdy;
  assign b.ready    = w_b_rdy;
  assign a.rvalid   = r_t2_v && !r_t2_b;
  assign b.rvalid   = r_t2_v && r_t2_b;
  assign a.rdata    = sram_dout;
  assign b.rdata    = sram_dout;
  assign init_done  = r_done;
  assign sram_rstb  = !rst;
  assign sram_ce    = r_ce;
  assign sram_we    = r_we;
  assign sram_wmask = r_wmask;
  assign sram_addr  = r_addr;
  assign sram_din   = r_din;

  // Sweep sequencing: count through every word, then stay in RUN until reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= INIT_EN ? S_INIT : S_RUN;
      r_cnt   <= '0;
      r_done  <= !INIT_EN;
    end else begin
      if (w_init) begin
        r_cnt <= r_cnt + 1'b1;
        if (r_cnt == LAST) r_state <= S_RUN;
      end
      r_done <= r_done || (r_state == S_RUN);
    end
  end

  // Remember the last served port on every accept.
  always_ff @(posedge clk) begin
    if (rst) r_last_b <= 1'b1;
    else if (w_a_rdy) r_last_b <= 1'b0;
    else if (w_b_rdy) r_last_b <= 1'b1;
  end

  // Macro command register: sweep write, granted request, or idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ce    <= 1'b0;
      r_we    <= 1'b0;
      r_wmask <= '0;
      r_addr  <= '0;
      r_din   <= '0;
    end else begin
      unique case (1'b1)
        w_init: begin
          r_ce    <= 1'b1;
          r_we    <= 1'b1;
          r_wmask <= '1;
          r_addr  <= r_cnt;
          r_din   <= '0;
        end
        w_a_rdy: begin
          r_ce    <= 1'b1;
          r_we    <= a.we;
          r_wmask <= a.wmask;
          r_addr  <= a.addr;
          r_din   <= a.wdata;
        end
        w_b_rdy: begin
          r_ce    <= 1'b1;
          r_we    <= b.we;
          r_wmask <= b.wmask;
          r_addr  <= b.addr;
          r_din   <= b.wdata;
        end
        default: r_ce <= 1'b0;
      endcase
    end
  end

  // Read tag pipe: tracks which port owns the data two cycles after accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_t1_v <= 1'b0;
      r_t1_b <= 1'b0;
      r_t2_v <= 1'b0;
      r_t2_b <= 1'b0;
    end else begin
      r_t1_v <= (w_a_rdy && !a.we) || (w_b_rdy && !b.we);
      r_t1_b <= w_b_rdy;
      r_t2_v <= r_t1_v;
      r_t2_b <= r_t1_b;
    end
  end

endmodule

// File: tb/tb_sram22_arb2_ctrl.sv
// Bench for sram22_arb2_ctrl: macro model, reference model,
// arbitration table, corner sequences and random traffic.
module tb_sram22_arb2_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  sram22_arb2_if #(.AW(11), .DW(8), .MW(8)) ia ();
  sram22_arb2_if #(.AW(11), .DW(8), .MW(8)) ib ();
  sram22_arb2_if #(.AW(4), .DW(8), .MW(8)) ia2 ();
  sram22_arb2_if #(.AW(4), .DW(8), .MW(8)) ib2 ();

  logic        init_done, sram_rstb, sram_ce, sram_we;
  logic [7:0]  sram_wmask, sram_din, sram_dout;
  logic [10:0] sram_addr;

  logic        init_done2, sram2_rstb, sram2_ce, sram2_we;
  logic [7:0]  sram2_wmask, sram2_din, sram2_dout;
  logic [3:0]  sram2_addr;
  assign sram2_dout = 8'h00;

  sram22_arb2_ctrl #(
    .ADDR_WIDTH(11), .DATA_WIDTH(8), .WMASK_WIDTH(8), .INIT_EN(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .a(ia), .b(ib),
    .init_done(init_done), .sram_rstb(sram_rstb),
    .sram_ce(sram_ce), .sram_we(sram_we), .sram_wmask(sram_wmask),
    .sram_addr(sram_addr), .sram_din(sram_din), .sram_dout(sram_dout)
  );

  sram22_arb2_ctrl #(
    .ADDR_WIDTH(4), .DATA_WIDTH(8), .WMASK_WIDTH(8), .INIT_EN(1'b0)
  ) dut2 (
    .clk(clk), .rst(rst), .a(ia2), .b(ib2),
    .init_done(init_done2), .sram_rstb(sram2_rstb),
    .sram_ce(sram2_ce), .sram_we(sram2_we), .sram_wmask(sram2_wmask),
    .sram_addr(sram2_addr), .sram_din(sram2_din), .sram_dout(sram2_dout)
  );

  // Behavioural sram22 macro, starts with non-zero garbage.
  logic [7:0] mem [2048];
  initial begin
    for (int i = 0; i < 2048; i++) mem[i] <= 8'h5A;
    sram_dout <= 8'h00;
  end
  always @(posedge clk) begin
    if (sram_ce === 1'b1) begin
      if (sram_we) begin
        for (int i = 0; i < 8; i++)
          if (sram_wmask[i]) mem[sram_addr][i] <= sram_din[i];
      end else begin
        sram_dout <= mem[sram_addr];
      end
    end
  end

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                  name, act, exp, cyc);
  endtask

  // Reference model: contents, fairness pointer, expected command and replies.
  typedef struct {
    int         due;
    bit         port_b;
    logic [7:0] data;
  } resp_t;

  logic [7:0]  ref_mem [2048];
  resp_t       rq [$];
  bit          m_last_b = 1'b1;
  bit          m_ce = 1'b0;
  bit          m_we;
  logic [7:0]  m_mask, m_din;
  logic [10:0] m_addr;

  bit          s_ga, s_gb, s_rva, s_rvb;
  logic [7:0]  s_rda, s_rdb;

  task automatic step(input bit av, input bit bv,
                      input bit awe, input bit bwe,
                      input logic [10:0] aa, input logic [10:0] ba,
                      input logic [7:0] ad, input logic [7:0] bd,
                      input logic [7:0] am, input logic [7:0] bm);
    bit ga, gb, era, erb;
    logic [7:0] eda, edb;
    resp_t r;
    @(negedge clk);
    ia.valid = av; ia.we = awe; ia.addr = aa; ia.wdata = ad; ia.wmask = am;
    ib.valid = bv; ib.we = bwe; ib.addr = ba; ib.wdata = bd; ib.wmask = bm;
    #1;
    ga = av && (!bv || m_last_b);
    gb = bv && !ga;
    chk("a_ready", ia.ready, ga);
    chk("b_ready", ib.ready, gb);
    chk("sram_rstb", sram_rstb, 1);
    chk("sram_ce", sram_ce, m_ce);
    if (m_ce) begin
      chk("sram_we", sram_we, m_we);
      chk("sram_addr", sram_addr, m_addr);
      if (m_we) begin
        chk("sram_din", sram_din, m_din);
        chk("sram_wmask", sram_wmask, m_mask);
      end
    end
    era = 0; erb = 0; eda = 0; edb = 0;
    if (rq.size() > 0 && rq[0].due == cyc) begin
      r = rq.pop_front();
      if (r.port_b) begin erb = 1; edb = r.data; end
      else begin era = 1; eda = r.data; end
    end
    chk("a_rvalid", ia.rvalid, era);
    chk("b_rvalid", ib.rvalid, erb);
    if (era) chk("a_rdata", ia.rdata, eda);
    if (erb) chk("b_rdata", ib.rdata, edb);
    s_ga = ia.ready; s_gb = ib.ready;
    s_rva = ia.rvalid; s_rvb = ib.rvalid;
    s_rda = ia.rdata; s_rdb = ib.rdata;
    m_ce = ga || gb;
    if (m_ce) begin
      m_last_b = gb;
      m_we   = gb ? bwe : awe;
      m_addr = gb ? ba : aa;
      m_din  = gb ? bd : ad;
      m_mask = gb ? bm : am;
      if (m_we)
        ref_mem[m_addr] = (ref_mem[m_addr] & ~m_mask) | (m_din & m_mask);
      else
        rq.push_back('{due: cyc + 2, port_b: gb, data: ref_mem[m_addr]});
    end
    @(posedge clk);
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Watch the zero-fill with both clients requesting the whole time.
  task automatic run_sweep();
    int n, nxt, first;
    bit bad, rv, fin;
    n = 0; nxt = 0; first = -1; bad = 0; rv = 0; fin = 0;
    ia.valid = 1; ia.we = 0; ia.addr = 11'd7;
    ib.valid = 1; ib.we = 0; ib.addr = 11'd8;
    for (int i = 0; i < 2200 && !fin; i++) begin
      @(negedge clk);
      #1;
      if (ia.rvalid || ib.rvalid) rv = 1;
      if (sram_ce) begin
        if (first < 0) first = int'(sram_addr);
        if (!sram_we || sram_addr != nxt[10:0] || sram_din != 8'h00 ||
            sram_wmask != 8'hFF) bad = 1;
        nxt++;
        n++;
      end
      if (ia.ready || ib.ready) begin
        fin = 1;
        chk("held_a_first", ia.ready, 1);
        chk("held_b_wait", ib.ready, 0);
        chk("done_low_at_last", init_done, 0);
        chk("last_sweep_addr", sram_addr, 11'd2047);
        ia.valid = 0;
        ib.valid = 0;
      end
    end
    chk("sweep_finished", fin, 1);
    chk("sweep_count", n, 2048);
    chk("sweep_first_addr", first, 0);
    chk("sweep_format_bad", bad, 0);
    chk("sweep_rvalid", rv, 0);
    for (int i = 0; i < 2048; i++) ref_mem[i] = 8'h00;
    rq.delete();
    m_ce = 0;
    @(posedge clk);
    @(negedge clk);
    chk("init_done_high", init_done, 1);
    chk("post_sweep_ce", sram_ce, 0);
    @(posedge clk);
  endtask

  typedef struct {
    bit av, bv, era, erb;
  } vec_t;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [8];
    bit prev_b, alt;
    int na, nb;

    tbl[0] = '{1, 1, 1, 0};
    tbl[1] = '{1, 1, 0, 1};
    tbl[2] = '{1, 0, 1, 0};
    tbl[3] = '{1, 1, 0, 1};
    tbl[4] = '{0, 1, 0, 1};
    tbl[5] = '{1, 1, 1, 0};
    tbl[6] = '{0, 0, 0, 0};
    tbl[7] = '{0, 1, 0, 1};

    ia.valid = 0; ia.we = 0; ia.addr = 0; ia.wdata = 0; ia.wmask = 0;
    ib.valid = 0; ib.we = 0; ib.addr = 0; ib.wdata = 0; ib.wmask = 0;
    ia2.valid = 1; ia2.we = 0; ia2.addr = 0; ia2.wdata = 0; ia2.wmask = 0;
    ib2.valid = 1; ib2.we = 0; ib2.addr = 0; ib2.wdata = 0; ib2.wmask = 0;
    rst = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_a_ready", ia.ready, 0);
    chk("rst_b_ready", ib.ready, 0);
    chk("rst_a_rvalid", ia.rvalid, 0);
    chk("rst_b_rvalid", ib.rvalid, 0);
    chk("rst_sram_ce", sram_ce, 0);
    chk("rst_sram_we", sram_we, 0);
    chk("rst_sram_addr", sram_addr, 0);
    chk("rst_sram_din", sram_din, 0);
    chk("rst_sram_wmask", sram_wmask, 0);
    chk("rst_init_done", init_done, 0);
    chk("rst_sram_rstb", sram_rstb, 0);
    chk("noinit_rst_ready", ia2.ready, 0);
    chk("noinit_rst_done", init_done2, 1);
    rst = 0;
    #1;
    chk("noinit_a_ready", ia2.ready, 1);
    chk("noinit_b_ready", ib2.ready, 0);
    chk("noinit_done", init_done2, 1);
    ia2.valid = 0;
    ib2.valid = 0;
    m_last_b = 1;
    m_ce = 0;
    rq.delete();
    run_sweep();

    // Arbitration table; reads of freshly zeroed words.
    foreach (tbl[i]) begin
      step(tbl[i].av, tbl[i].bv, 0, 0, 11'(i), 11'(100 + i), 0, 0, 0, 0);
      chk("tbl_a_ready", s_ga, tbl[i].era);
      chk("tbl_b_ready", s_gb, tbl[i].erb);
    end
    idle();
    idle();

    // A writes 5, B reads it back the next cycle.
    step(1, 0, 1, 0, 11'd5, 0, 8'hA5, 0, 8'hFF, 0);
    step(0, 1, 0, 0, 0, 11'd5, 0, 0, 0, 0);
    idle();
    chk("wr_rd_early_rvalid", s_rvb, 0);
    idle();
    chk("wr_rd_b_rvalid", s_rvb, 1);
    chk("wr_rd_b_rdata", s_rdb, 8'hA5);
    chk("wr_rd_a_quiet", s_rva, 0);

    // Masked overwrite.
    step(1, 0, 1, 0, 11'd9, 0, 8'hFF, 0, 8'hFF, 0);
    step(1, 0, 1, 0, 11'd9, 0, 8'h00, 0, 8'h0F, 0);
    step(1, 0, 0, 0, 11'd9, 0, 0, 0, 0, 0);
    idle();
    idle();
    chk("mask_rvalid", s_rva, 1);
    chk("mask_rdata", s_rda, 8'hF0);

    // Continuous contention alternates without bubbles.
    na = 0; nb = 0; alt = 1; prev_b = m_last_b;
    for (int i = 0; i < 8; i++) begin
      step(1, 1, 0, 0, 11'(20 + i), 11'(40 + i), 0, 0, 0, 0);
      if (s_ga) na++;
      if (s_gb) nb++;
      if (!(s_ga ^ s_gb) || s_gb == prev_b) alt = 0;
      prev_b = s_gb;
    end
    idle();
    idle();
    chk("rr_a_grants", na, 4);
    chk("rr_b_grants", nb, 4);
    chk("rr_alternate", alt, 1);

    // Random mixed traffic against the model.
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
           11'($urandom_range(0, 15)), 11'($urandom_range(0, 15)),
           8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
    end
    idle();
    idle();

    // Read accepted, then reset at the following edge.
    step(1, 0, 0, 0, 11'd3, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1;
    ia.valid = 0;
    ib.valid = 0;
    @(negedge clk);
    chk("midrst_a_rvalid", ia.rvalid, 0);
    chk("midrst_b_rvalid", ib.rvalid, 0);
    chk("midrst_ce", sram_ce, 0);
    chk("midrst_done", init_done, 0);
    rst = 0;
    m_last_b = 1;
    m_ce = 0;
    rq.delete();
    run_sweep();

    for (int i = 0; i < 40; i++) begin
      step(1'($urandom), 1'($urandom), 0, 0,
           11'($urandom_range(0, 2047)), 11'($urandom_range(0, 2047)),
           0, 0, 0, 0);
    end
    idle();
    idle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
